// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand-issue stage feeding the 32-bit ALU
// Holds the register file and a per-register pending-writeback scoreboard.
// It resolves rs/rt/immediate operands with writeback bypass and presents
// them through a one-entry output register.
// Ports: clk, rst_n (async low); wr_en/wr_addr/wr_data writeback;
//        in_* decoded instruction with in_valid/in_ready;
//        A/B/alu_op/out_rd/out_wr with out_valid/out_ready.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wr,
    input  logic              in_use_imm,
    input  logic              in_sign_ext,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        alu_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wr
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   pend_q, pend_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              wr_q, wr_d;

    logic              wr_live;
    logic [NREG-1:0]   pend_eff;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;

    assign wr_live = wr_en && (wr_addr != '0);

    // A register whose writeback lands this cycle is not a hazard: the
    // bypass supplies its value.
    always_comb begin
        pend_eff = pend_q;
        if (wr_en) pend_eff[wr_addr] = 1'b0;
    end

    assign hazard = in_valid && (pend_eff[in_rs] ||
                                 (pend_eff[in_rt] && !in_use_imm) ||
                                 (in_wr && pend_eff[in_rd]));
    assign in_ready = !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        if (in_rs == '0)                    rs_val = '0;
        else if (wr_en && wr_addr == in_rs) rs_val = wr_data;
        else                                rs_val = rf_q[in_rs];
        if (in_rt == '0)                    rt_val = '0;
        else if (wr_en && wr_addr == in_rt) rt_val = wr_data;
        else                                rt_val = rf_q[in_rt];
    end

    assign imm_ext = {{(DATA_W-IMM_W){in_sign_ext & in_imm[IMM_W-1]}}, in_imm};

    always_comb begin
        for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
        if (wr_live) rf_d[wr_addr] = wr_data;
    end

    // Clear first so a same-edge set on the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) pend_d[wr_addr] = 1'b0;
        if (accept && in_wr && in_rd != '0) pend_d[in_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = rs_val;
            b_d     = in_use_imm ? imm_ext : rt_val;
            op_d    = in_alu_op;
            rd_d    = in_rd;
            wr_d    = in_wr;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
            pend_q  <= pend_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign out_valid = valid_q;
    assign A         = a_q;
    assign B         = b_q;
    assign alu_op    = op_q;
    assign out_rd    = rd_q;
    assign out_wr    = wr_q;
endmodule
